// File: rtl/ps2_command_out.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts one command
// byte out on device-generated clock edges and checks the device's acknowledge bit.
module ps2_command_out #(
  parameter int INHIBIT_CYCLES       = 5000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] command,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic       error_no_ack
);

  localparam int CMAX = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int XW   = $clog2(XFER_TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_WAIT_FIRST, S_SHIFT, S_WAIT_ACK, S_WAIT_IDLE, S_ERR_TO, S_ERR_NACK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [XW-1:0] xcnt, xcnt_n;
  logic [9:0]    shreg, shreg_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic          dat_oe_n, sent_n, to_n, nack_n;
  logic          clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic          fall, xfer_expired;

  // Synchronisers reset to the idle-high bus level so reset release never looks like an edge
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1; clk_prev <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in; clk_s2 <= clk_s1; clk_prev <= clk_s2;
      dat_s1 <= ps2_dat_in; dat_s2 <= dat_s1;
    end
  end

  assign fall         = clk_prev & ~clk_s2;
  assign xfer_expired = (xcnt == XW'(XFER_TIMEOUT_CYCLES - 1));
  assign ps2_clk_oe   = (state == S_INHIBIT) || (state == S_RTS);
  assign busy         = (state != S_IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    xcnt_n   = xcnt;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    dat_oe_n = ps2_dat_oe;
    sent_n   = 1'b0;
    to_n     = 1'b0;
    nack_n   = 1'b0;
    case (state)
      S_IDLE: begin
        dat_oe_n = 1'b0;
        if (send_command) begin
          shreg_n  = {1'b1, ~^command, command};
          cnt_n    = '0;
          bitcnt_n = '0;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_n    = '0;
          dat_oe_n = 1'b1;
          state_n  = S_RTS;
        end else cnt_n = cnt + 1'b1;
      end
      S_RTS: begin
        cnt_n   = '0;
        state_n = S_WAIT_FIRST;
      end
      S_WAIT_FIRST: begin
        if (fall) begin
          dat_oe_n = ~shreg[0];
          shreg_n  = {1'b1, shreg[9:1]};
          bitcnt_n = 4'd1;
          xcnt_n   = '0;
          state_n  = S_SHIFT;
        end else if (cnt == CW'(START_TIMEOUT_CYCLES - 1)) begin
          dat_oe_n = 1'b0;
          state_n  = S_ERR_TO;
        end else cnt_n = cnt + 1'b1;
      end
      S_SHIFT: begin
        if (xfer_expired) begin
          dat_oe_n = 1'b0;
          state_n  = S_ERR_TO;
        end else begin
          xcnt_n = xcnt + 1'b1;
          if (fall) begin
            dat_oe_n = ~shreg[0];
            shreg_n  = {1'b1, shreg[9:1]};
            bitcnt_n = bitcnt + 1'b1;
            // this edge drove the stop bit (10th edge)
            if (bitcnt == 4'd9) state_n = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        if (xfer_expired) state_n = S_ERR_TO;
        else begin
          xcnt_n = xcnt + 1'b1;
          if (fall) state_n = dat_s2 ? S_ERR_NACK : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (xfer_expired) state_n = S_ERR_TO;
        else begin
          xcnt_n = xcnt + 1'b1;
          if (clk_s2 && dat_s2) begin
            sent_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_ERR_TO: begin
        dat_oe_n = 1'b0;
        to_n     = 1'b1;
        state_n  = S_IDLE;
      end
      S_ERR_NACK: begin
        dat_oe_n = 1'b0;
        nack_n   = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Completion pulses are registered so they coincide with the first non-busy cycle
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state                         <= S_IDLE;
      cnt                           <= '0;
      xcnt                          <= '0;
      shreg                         <= '0;
      bitcnt                        <= '0;
      ps2_dat_oe                    <= 1'b0;
      command_was_sent              <= 1'b0;
      error_communication_timed_out <= 1'b0;
      error_no_ack                  <= 1'b0;
    end else begin
      state                         <= state_n;
      cnt                           <= cnt_n;
      xcnt                          <= xcnt_n;
      shreg                         <= shreg_n;
      bitcnt                        <= bitcnt_n;
      ps2_dat_oe                    <= dat_oe_n;
      command_was_sent              <= sent_n;
      error_communication_timed_out <= to_n;
      error_no_ack                  <= nack_n;
    end
  end

endmodule

// File: tb/tb_ps2_command_out.sv
// Bench for ps2_command_out: open-drain bus model, PS/2 device model and a pulse-driven scoreboard.
module tb_ps2_command_out;
  localparam int INH  = 200;
  localparam int STO  = 3000;
  localparam int XTO  = 4000;
  localparam int HALF = 20;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] command = 8'h00;
  logic       send_command = 1'b0;
  logic       ps2_clk_oe, ps2_dat_oe, busy;
  logic       command_was_sent, error_communication_timed_out, error_no_ack;
  logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  logic       clk_line, dat_line;

  assign clk_line = !(ps2_clk_oe || dev_clk_low);
  assign dat_line = !(ps2_dat_oe || dev_dat_low);

  ps2_command_out #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(STO), .XFER_TIMEOUT_CYCLES(XTO)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .command(command), .send_command(send_command),
    .ps2_clk_in(clk_line), .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .error_no_ack(error_no_ack)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // kind: 0 = acknowledged, 1 = timeout, 2 = no ack
  typedef struct { int kind; logic [7:0] data; } exp_t;
  exp_t exp_q[$];

  logic [7:0] dev_byte = 8'h00;
  logic       dev_par = 1'b0, dev_stop = 1'b0;

  function automatic int ref_parity(input logic [7:0] b);
    return (($countones(b) % 2) == 0) ? 1 : 0;
  endfunction

  // Device: waits for request-to-send, clocks 10 bits in, then the ack edge
  task automatic device(input bit clock_it, input bit ack);
    int t = 0;
    logic [9:0] bits;
    while (!(!ps2_clk_oe && !dat_line) && t < INH * 4) begin
      @(negedge CLOCK_50); t++;
    end
    check("rts_seen", int'(t < INH * 4), 1);
    if (!clock_it) return;
    repeat (HALF) @(negedge CLOCK_50);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1; repeat (HALF) @(negedge CLOCK_50);
      dev_clk_low = 1'b0; repeat (HALF) @(negedge CLOCK_50);
      bits[i] = dat_line;
    end
    dev_byte = bits[7:0]; dev_par = bits[8]; dev_stop = bits[9];
    dev_dat_low = ack; repeat (HALF / 2) @(negedge CLOCK_50);
    dev_clk_low = 1'b1; repeat (HALF) @(negedge CLOCK_50);
    dev_clk_low = 1'b0; repeat (HALF / 2) @(negedge CLOCK_50);
    dev_dat_low = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int mode, input bit noise, input logic [7:0] nb);
    int t0, k;
    exp_t e;
    @(negedge CLOCK_50);
    command = b; send_command = 1'b1;
    e.kind = mode; e.data = b; exp_q.push_back(e);
    @(negedge CLOCK_50);
    send_command = 1'b0; command = 8'($urandom);
    t0 = cyc;
    fork
      device(mode != 1, mode == 0);
      if (noise) begin
        repeat ($urandom_range(5, 600)) @(negedge CLOCK_50);
        if (busy) begin
          command = nb; send_command = 1'b1;
          @(negedge CLOCK_50);
          send_command = 1'b0;
        end
      end
    join
    k = 0;
    while (busy && k < INH + STO + XTO + 100) begin @(negedge CLOCK_50); k++; end
    check("done_in_time", int'(busy), 0);
    if (mode == 1) begin
      k = cyc - t0 - (INH + 1 + STO);
      check("timeout_latency", int'(k >= -2 && k <= 2), 1);
    end
    repeat (10) @(negedge CLOCK_50);
  endtask

  // Scoreboard monitor: pops one expectation per completion pulse
  always @(negedge CLOCK_50) begin
    int n, kind;
    exp_t e;
    n = int'(command_was_sent) + int'(error_communication_timed_out) + int'(error_no_ack);
    if (n > 0) begin
      check("single_pulse", n, 1);
      kind = command_was_sent ? 0 : (error_communication_timed_out ? 1 : 2);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: got kind %0d expected no pulse", kind);
      end else begin
        e = exp_q.pop_front();
        check("completion_kind", kind, e.kind);
        check("busy_at_done", int'(busy), 0);
        check("lines_released", int'({ps2_clk_oe, ps2_dat_oe}), 0);
        if (e.kind == 0) begin
          check("byte_on_wire", int'(dev_byte), int'(e.data));
          check("parity_bit", int'(dev_par), ref_parity(e.data));
          check("stop_bit", int'(dev_stop), 1);
        end
      end
    end
  end

  // Each inhibit-plus-RTS phase holds CLK low for INH+1 cycles
  int low_run = 0;
  always @(negedge CLOCK_50) begin
    if (ps2_clk_oe) low_run++;
    else if (low_run > 0) begin
      check("clk_low_len", low_run, INH + 1);
      low_run = 0;
    end
  end

  task automatic check_quiet(input string name);
    check(name, int'({ps2_clk_oe, ps2_dat_oe, busy, command_was_sent,
                      error_communication_timed_out, error_no_ack}), 0);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge CLOCK_50);
    check_quiet("reset_state");
    resetn = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    send(8'hF4, 0, 1'b1, 8'h55);
    send(8'h00, 0, 1'b0, 8'h00);
    send(8'hFF, 0, 1'b0, 8'h00);
    send(8'hF4, 1, 1'b0, 8'h00);
    send(8'hAA, 2, 1'b1, 8'h55);

    // reset while idle
    @(negedge CLOCK_50); #2 resetn = 1'b0; #1 check_quiet("reset_idle");
    @(negedge CLOCK_50); resetn = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // reset in the middle of the shift phase (no expectation pushed)
    command = 8'hA5; send_command = 1'b1;
    @(negedge CLOCK_50); send_command = 1'b0;
    t = 0;
    while (!(!ps2_clk_oe && !dat_line) && t < INH * 4) begin @(negedge CLOCK_50); t++; end
    check("rts_seen_mid", int'(t < INH * 4), 1);
    repeat (HALF) @(negedge CLOCK_50);
    repeat (3) begin
      dev_clk_low = 1'b1; repeat (HALF) @(negedge CLOCK_50);
      dev_clk_low = 1'b0; repeat (HALF) @(negedge CLOCK_50);
    end
    dev_clk_low = 1'b1; repeat (8) @(negedge CLOCK_50);
    check("pre_reset_d3_driven", int'(ps2_dat_oe), 1);
    #2 resetn = 1'b0; #1 check_quiet("reset_mid_shift");
    dev_clk_low = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (50) @(negedge CLOCK_50);

    for (int i = 0; i < 12; i++) begin
      int r, mode;
      r = $urandom_range(0, 9);
      mode = (r < 7) ? 0 : ((r < 9) ? 2 : 1);
      send(8'($urandom), mode, 1'($urandom), 8'($urandom));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
